nfc_atom_ca_issue: RTL and testbench
====================================

Name: nfc_atom_ca_issue

Overview:
- Atomic command/address (CA) latch generator. Sits directly downstream of the command blocks (reset, read, program, ...).
- Consumes their ACG command bus and the bit-6 "CA issue" request.
- Serialises up to 5 CA bytes onto the NAND SDR pins (CE#/CLE/ALE/WE#/DQ) with programmable cycle timing.
- Returns ready and a one-cycle last-step pulse. This output feeds the ACG_Ready[6] / ACG_LastStep[6] inputs of the command blocks.

Parameters:
- NumberOfWays, 4: number of ways/chip-enables.
- CommandBit, 6: index of the iCommand bit that requests this atom.
- TCS, 2: setup cycles (CE#/CLE/ALE/DQ valid before the first WE# fall), 1..15.
- TWP, 2: WE# low cycles per byte, 1..15.
- TWH, 2: WE# high cycles per byte, 1..15.
- TCH, 1: hold cycles after the last WE# rise before release, 1..15.

Ports:
- iSystemClock, in, 1: system clock.
- iReset, in, 1: asynchronous, active-low reset.
- iCommand, in, 8: one-hot atom request bus; bit CommandBit starts this block.
- iCommandOption, in, 3: bit0 = keep CE (see Optional Feature); bits 2:1 ignored.
- iTargetWay, in, NumberOfWays: way mask, 0 = way selected.
- iNumOfData, in, 16: number of CA bytes.
- iCASelect, in, 1: 1 = command cycles (CLE), 0 = address cycles (ALE).
- iCAData, in, 40: CA bytes, first byte in [39:32].
- oReady, out, 1: idle and able to accept.
- oLastStep, out, 1: one-cycle completion pulse.
- oCE_n, out, NumberOfWays: chip enables, active-low.
- oCLE, out, 1: command latch enable.
- oALE, out, 1: address latch enable.
- oWE_n, out, 1: write enable, active-low.
- oDQ, out, 8: data bus value.
- oDQOutEnable, out, 1: DQ output enable.

Behaviour:
- Reset (iReset=0, asynchronous, any state): FSM goes to IDLE.
  - Outputs: oReady=1, oLastStep=0, oCE_n=all 1, oCLE=0, oALE=0, oWE_n=1, oDQ=8'h00, oDQOutEnable=0.
  - Mid-operation reset aborts immediately; no oLastStep is produced.
- All outputs are registered.
- States: IDLE, SETUP, WELOW, WEHIGH, HOLD, DONE, REARM.
- Accept: in IDLE, iCommand[CommandBit]=1 latches the following and moves to SETUP; oReady goes to 0 on the same edge.
  - iTargetWay, iCASelect, iCAData.
  - Byte count N = min(iNumOfData, 5). Bits above [2:0] participate in the compare, so 16'h0009 clamps to 5.
- N=0: IDLE -> DONE. No pin activity, oCE_n stays all 1. oLastStep pulses on the next edge.
- SETUP (TCS cycles):
  - oCE_n = latched way mask.
  - oCLE = iCASelect, oALE = ~iCASelect.
  - oDQ = byte 0, oDQOutEnable=1, oWE_n=1.
- WELOW (TWP cycles): oWE_n=0.
- WEHIGH (TWH cycles): oWE_n=1.
  - At its end, if bytes remain: shift the data left 8 bits, drive the next byte on oDQ, return to WELOW.
  - Otherwise go to HOLD.
- HOLD (TCH cycles): pins held, oWE_n=1.
- DONE (1 cycle):
  - oLastStep=1.
  - oCLE=0, oALE=0, oDQOutEnable=0, oDQ=0.
  - oCE_n=all 1 (unless kept, see Optional Feature).
- REARM (1 cycle): oReady stays 0 and iCommand is ignored. This covers the requester still holding the command bit while it samples oLastStep. Then IDLE, oReady=1.
- Latency: accepting edge to oLastStep high = TCS + N*(TWP+TWH) + TCH edges. Defaults: N=1 gives 7, N=5 gives 23.
- oReady high again exactly 2 edges after oLastStep rises.
- Phase counter is 4 bits and reloads on each state entry. Byte counter is 3 bits, decremented at each WEHIGH exit.
- Changes on iCommand/iTargetWay/iCAData while busy are ignored.

Optional Feature:
- Macro NFC_CA_KEEP_CE_EN.
- Defined: iCommandOption[0]=1 at accept keeps oCE_n at the latched mask through DONE, REARM and IDLE. CE is released on the next accept with option 0, or on reset.
- Undefined: iCommandOption is ignored; CE is always released in DONE.

Test Plan:
- Reset command: iTargetWay=4'b1110, iCASelect=1, iCAData=40'hFF00000000, iNumOfData=1, command bit6 held.
  - Required: oCE_n=1110, oCLE=1, oDQ=FF, one WE# low pulse of 2 cycles.
  - oLastStep at edge 7; oReady=1 at edge 9; no second issue although bit6 is still high at the pulse.
- Address issue: iCASelect=0, iCAData=40'h1122334455, N=5.
  - Required: oALE=1, bytes 11,22,33,44,55 each stable across its WE# rise.
  - 5 WE# pulses; oLastStep at edge 23.
- iNumOfData=0: oLastStep one edge after accept, oWE_n never 0, oCE_n stays 1111.
- iNumOfData=16'h0009: exactly 5 WE# pulses.
- iReset low during the 3rd byte: outputs return to reset values immediately, no oLastStep. After release, a new 1-byte command completes normally.
- With NFC_CA_KEEP_CE_EN, option0=1, way 1110: oCE_n stays 1110 after DONE. The next command with option0=0 releases it to 1111 at its DONE.

Source files
------------

// File: rtl/nfc_atom_ca_issue_if.sv
// nfc_atom_ca_issue_if: ACG command bus in, NAND SDR CA pins out, for the CA issue atom.
interface nfc_atom_ca_issue_if #(
  parameter int NumberOfWays = 4
);
  logic [7:0]              iCommand;
  logic [2:0]              iCommandOption;
  logic [NumberOfWays-1:0] iTargetWay;
  logic [15:0]             iNumOfData;
  logic                    iCASelect;
  logic [39:0]             iCAData;
  logic                    oReady;
  logic                    oLastStep;
  logic [NumberOfWays-1:0] oCE_n;
  logic                    oCLE;
  logic                    oALE;
  logic                    oWE_n;
  logic [7:0]              oDQ;
  logic                    oDQOutEnable;
  modport master (
    output iCommand, iCommandOption, iTargetWay, iNumOfData, iCASelect, iCAData,
    input  oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOutEnable
  );
  modport slave (
    input  iCommand, iCommandOption, iTargetWay, iNumOfData, iCASelect, iCAData,
    output oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOutEnable
  );
endinterface

// File: rtl/nfc_atom_ca_issue.sv
// nfc_atom_ca_issue: serialises up to 5 CLE/ALE bytes onto NAND SDR pins; NFC_CA_KEEP_CE_EN keeps CE asserted after completion.
module nfc_atom_ca_issue #(
  parameter int NumberOfWays = 4,
  parameter int CommandBit   = 6,
  parameter int TCS          = 2,
  parameter int TWP          = 2,
  parameter int TWH          = 2,
  parameter int TCH          = 1
) (
  input logic iSystemClock,
  input logic iReset,
  nfc_atom_ca_issue_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, WELOW, WEHIGH, HOLD, DONE, REARM} state_t;
  state_t state, stateN;
  logic [3:0] phase, phaseN;
  logic [2:0] count, countN, numClamp;
  logic [39:0] data, dataN;
  logic [NumberOfWays-1:0] way, wayN, ceN;
  logic sel, selN, keep, keepN, keepReq, active, unusedInputs;
`ifdef NFC_CA_KEEP_CE_EN
  assign keepReq = bus.iCommandOption[0];
  assign unusedInputs = ^{bus.iCommandOption[2:1], bus.iCommand};
`else
  assign keepReq = 1'b0;
  assign unusedInputs = ^{bus.iCommandOption, bus.iCommand};
`endif
  assign numClamp = (bus.iNumOfData > 16'd5) ? 3'd5 : bus.iNumOfData[2:0];
  // a zero-length request waits one cycle in DONE so its pulse lands one edge after accept
  always_comb begin
    stateN = state;
    phaseN = phase - 4'd1;
    countN = count;
    dataN = data;
    wayN = way;
    selN = sel;
    keepN = keep;
    case (state)
      IDLE: if (bus.iCommand[CommandBit]) begin
        wayN = bus.iTargetWay;
        selN = bus.iCASelect;
        dataN = bus.iCAData;
        countN = numClamp;
        keepN = keepReq && numClamp != 3'd0;
        stateN = (numClamp == 3'd0) ? DONE : SETUP;
        phaseN = (numClamp == 3'd0) ? 4'd1 : 4'(TCS - 1);
      end
      SETUP: if (phase == 4'd0) begin
        stateN = WELOW;
        phaseN = 4'(TWP - 1);
      end
      WELOW: if (phase == 4'd0) begin
        stateN = WEHIGH;
        phaseN = 4'(TWH - 1);
      end
      WEHIGH: if (phase == 4'd0) begin
        countN = count - 3'd1;
        stateN = (count > 3'd1) ? WELOW : HOLD;
        phaseN = (count > 3'd1) ? 4'(TWP - 1) : 4'(TCH - 1);
        dataN = (count > 3'd1) ? {data[31:0], 8'h00} : data;
      end
      HOLD: if (phase == 4'd0) begin
        stateN = DONE;
        phaseN = 4'd0;
      end
      DONE: if (phase == 4'd0) stateN = REARM;
      default: stateN = IDLE;
    endcase
    active = stateN inside {SETUP, WELOW, WEHIGH, HOLD};
    ceN = (active || (keepN && stateN inside {DONE, REARM, IDLE})) ? wayN : '1;
  end
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state <= IDLE;
      phase <= 4'd0;
      count <= 3'd0;
      data <= '0;
      way <= '1;
      sel <= 1'b0;
      keep <= 1'b0;
      bus.oReady <= 1'b1;
      bus.oLastStep <= 1'b0;
      bus.oCE_n <= '1;
      bus.oCLE <= 1'b0;
      bus.oALE <= 1'b0;
      bus.oWE_n <= 1'b1;
      bus.oDQ <= 8'h00;
      bus.oDQOutEnable <= 1'b0;
    end else begin
      state <= stateN;
      phase <= phaseN;
      count <= countN;
      data <= dataN;
      way <= wayN;
      sel <= selN;
      keep <= keepN;
      bus.oReady <= stateN == IDLE;
      bus.oLastStep <= stateN == DONE && phaseN == 4'd0;
      bus.oCE_n <= ceN;
      bus.oCLE <= active && selN;
      bus.oALE <= active && !selN;
      bus.oWE_n <= stateN != WELOW;
      bus.oDQ <= active ? dataN[39:32] : 8'h00;
      bus.oDQOutEnable <= active;
    end
  end
endmodule

// File: tb/tb_nfc_atom_ca_issue.sv
// tb_nfc_atom_ca_issue: scoreboard bench for the CA issue atom; expected bytes are queued at issue and checked at each WE# rise.
module tb_nfc_atom_ca_issue;
  localparam int W = 4, TCS = 2, TWP = 2, TWH = 2, TCH = 1;
`ifdef NFC_CA_KEEP_CE_EN
  localparam bit KeepEn = 1'b1;
`else
  localparam bit KeepEn = 1'b0;
`endif
  typedef struct packed {logic [7:0] dq; logic cle; logic ale; logic [3:0] ce;} pin_t;
  logic iSystemClock = 1'b0;
  logic iReset = 1'b0;
  pin_t expQ[$];
  pin_t e, g;
  int vectors = 0, miscompares = 0, cyc = 0, lsCount = 0, lsEdge = 0, weRises = 0, lowRun = 0;
  bit prevWe = 1'b1, ceTouched = 1'b0;
  always #5 iSystemClock = ~iSystemClock;
  nfc_atom_ca_issue_if #(.NumberOfWays(W)) bus ();
  nfc_atom_ca_issue #(.NumberOfWays(W), .CommandBit(6), .TCS(TCS), .TWP(TWP), .TWH(TWH), .TCH(TCH)) dut (
    .iSystemClock(iSystemClock),
    .iReset(iReset),
    .bus(bus.slave)
  );
  always @(posedge iSystemClock) cyc <= cyc + 1;
  // pin monitor: each WE# rise pops the byte the bench expects to be latched
  always @(negedge iSystemClock) begin
    if (!iReset) begin
      prevWe = 1'b1;
      lowRun = 0;
    end else begin
      if (bus.oLastStep === 1'b1) begin
        lsCount++;
        lsEdge = cyc;
      end
      if (bus.oCE_n !== 4'hF) ceTouched = 1'b1;
      if (bus.oWE_n === 1'b0) lowRun++;
      else if (!prevWe) begin
        weRises++;
        vectors++;
        g = {bus.oDQ, bus.oCLE, bus.oALE, bus.oCE_n};
        if (expQ.size() == 0) begin
          miscompares++;
          $display("FAIL we_rise_unexpected: got dq=%h cle=%b ale=%b ce=%b, required no WE# pulse", g.dq, g.cle, g.ale, g.ce);
        end else begin
          e = expQ.pop_front();
          if (g !== e || bus.oDQOutEnable !== 1'b1 || lowRun != TWP) begin
            miscompares++;
            $display("FAIL we_rise: got dq=%h cle=%b ale=%b ce=%b oe=%b low=%0d, required dq=%h cle=%b ale=%b ce=%b oe=1 low=%0d",
                     g.dq, g.cle, g.ale, g.ce, bus.oDQOutEnable, lowRun, e.dq, e.cle, e.ale, e.ce, TWP);
          end
        end
        lowRun = 0;
      end
      prevWe = bus.oWE_n;
    end
  end
  task automatic drive(input logic [3:0] way, input bit sel, input logic [39:0] data, input logic [15:0] num, input bit opt);
    int n;
    n = (num > 16'd5) ? 5 : int'(num);
    bus.iCommand = 8'h40;
    bus.iCommandOption = {2'b10, opt};
    bus.iTargetWay = way;
    bus.iNumOfData = num;
    bus.iCASelect = sel;
    bus.iCAData = data;
    for (int i = 0; i < n; i++) expQ.push_back({data[39-8*i -: 8], sel, !sel, way});
  endtask
  task automatic run_cmd(input string name, input logic [3:0] way, input bit sel, input logic [39:0] data, input logic [15:0] num, input bit opt);
    int n, lat, a, base, rb;
    logic [3:0] ce;
    logic [17:0] exp0, got0;
    n = (num > 16'd5) ? 5 : int'(num);
    lat = (n == 0) ? 1 : TCS + n * (TWP + TWH) + TCH;
    ce = (KeepEn && opt && n != 0) ? way : 4'hF;
    @(posedge iSystemClock); #1;
    vectors++;
    if (bus.oReady !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_before: got %b, required 1", name, bus.oReady);
    end
    drive(way, sel, data, num, opt);
    base = lsCount;
    rb = weRises;
    ceTouched = 1'b0;
    @(posedge iSystemClock); #1;
    a = cyc;
    exp0 = (n == 0) ? {1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}
                    : {1'b0, way, sel, !sel, data[39:32], 1'b1, 1'b1, 1'b0};
    got0 = {bus.oReady, bus.oCE_n, bus.oCLE, bus.oALE, bus.oDQ, bus.oWE_n, bus.oDQOutEnable, bus.oLastStep};
    vectors++;
    if (got0 !== exp0) begin
      miscompares++;
      $display("FAIL %s_accept_pins: got %h, required %h", name, got0, exp0);
    end
    for (int k = 0; k < 100 && lsCount == base; k++) begin
      @(negedge iSystemClock); #1;
    end
    vectors++;
    if (lsCount != base + 1 || lsEdge - a != lat) begin
      miscompares++;
      $display("FAIL %s_latency: got pulses=%0d edges=%0d, required pulses=1 edges=%0d", name, lsCount - base, lsEdge - a, lat);
    end
    vectors++;
    if ({bus.oCE_n, bus.oCLE, bus.oALE, bus.oDQOutEnable, bus.oDQ} !== {ce, 3'b000, 8'h00}) begin
      miscompares++;
      $display("FAIL %s_done_pins: got ce=%b cle=%b ale=%b oe=%b dq=%h, required ce=%b 0 0 0 00",
               name, bus.oCE_n, bus.oCLE, bus.oALE, bus.oDQOutEnable, bus.oDQ, ce);
    end
    @(posedge iSystemClock); #1;
    vectors++;
    if ({bus.oReady, bus.oLastStep} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_rearm: got ready=%b last=%b, required 0 0", name, bus.oReady, bus.oLastStep);
    end
    @(posedge iSystemClock); #1;
    vectors++;
    if (bus.oReady !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_after: got %b, required 1", name, bus.oReady);
    end
    bus.iCommand = 8'h00;
    repeat (4) @(posedge iSystemClock);
    #1;
    vectors++;
    if (lsCount != base + 1 || weRises - rb != n || expQ.size() != 0 || bus.oCE_n !== ce || (n == 0 && ceTouched)) begin
      miscompares++;
      $display("FAIL %s_quiet: got pulses=%0d rises=%0d left=%0d ce=%b touched=%b, required pulses=1 rises=%0d left=0 ce=%b touched=0",
               name, lsCount - base, weRises - rb, expQ.size(), bus.oCE_n, ceTouched, n, ce);
    end
    expQ.delete();
  endtask
  task automatic check_reset_pins(input string name);
    logic [17:0] got;
    got = {bus.oReady, bus.oLastStep, bus.oCE_n, bus.oCLE, bus.oALE, bus.oWE_n, bus.oDQ, bus.oDQOutEnable};
    vectors++;
    if (got !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge iSystemClock);
    #1;
    check_reset_pins("reset_held");
    iReset = 1'b1;
    @(posedge iSystemClock); #1;
    check_reset_pins("reset_released");
  endtask
  task automatic test_reset_cmd();
    run_cmd("reset_cmd", 4'b1110, 1'b1, 40'hFF00000000, 16'd1, 1'b0);
  endtask
  task automatic test_address();
    run_cmd("address", 4'b1101, 1'b0, 40'h1122334455, 16'd5, 1'b0);
  endtask
  task automatic test_zero_len();
    run_cmd("zero_len", 4'b1011, 1'b1, 40'hA5A5A5A5A5, 16'd0, 1'b0);
  endtask
  task automatic test_clamp();
    run_cmd("clamp", 4'b0111, 1'b0, 40'hA1B2C3D4E5, 16'h0009, 1'b0);
  endtask
  task automatic test_async_reset();
    int base, rb;
    base = lsCount;
    rb = weRises;
    @(posedge iSystemClock); #1;
    drive(4'b1011, 1'b0, 40'h0102030405, 16'd5, 1'b0);
    for (int k = 0; k < 200 && !(weRises - rb == 2 && bus.oWE_n === 1'b0); k++) begin
      @(negedge iSystemClock); #1;
    end
    vectors++;
    if (!(weRises - rb == 2 && bus.oWE_n === 1'b0)) begin
      miscompares++;
      $display("FAIL abort_reach_byte3: got rises=%0d we=%b, required rises=2 we=0", weRises - rb, bus.oWE_n);
    end
    #2 iReset = 1'b0;
    #1 check_reset_pins("abort_immediate");
    bus.iCommand = 8'h00;
    expQ.delete();
    repeat (3) @(posedge iSystemClock);
    #1;
    vectors++;
    if (lsCount != base || weRises - rb != 2) begin
      miscompares++;
      $display("FAIL abort_quiet: got pulses=%0d rises=%0d, required pulses=0 rises=2", lsCount - base, weRises - rb);
    end
    iReset = 1'b1;
    run_cmd("after_abort", 4'b1110, 1'b1, 40'h3000000000, 16'd1, 1'b0);
  endtask
  task automatic test_keep_ce();
    run_cmd("keep_set", 4'b1110, 1'b1, 40'hE000000000, 16'd1, 1'b1);
    run_cmd("keep_clear", 4'b1110, 1'b1, 40'h7000000000, 16'd1, 1'b0);
  endtask
  initial begin
    bus.iCommand = 8'h00;
    bus.iCommandOption = 3'b000;
    bus.iTargetWay = 4'hF;
    bus.iNumOfData = 16'd0;
    bus.iCASelect = 1'b0;
    bus.iCAData = 40'h0;
    test_reset();
    test_reset_cmd();
    test_address();
    test_zero_len();
    test_clamp();
    test_async_reset();
    test_keep_ce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1);
  end
endmodule
